// File: rtl/cache_client_port.sv
// Requester-side agent for one cache client port: queues read/write commands,
// issues them one at a time to the cache read or write port, returns one response each.
module cache_client_port #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  output logic                     wr_req,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                req_q, req_d, write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;

  logic                full, push, pop, port_ready, tmo_hit;
  logic [ENT_W-1:0]    head;

  // cmd_ready comes from the registered count only, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign full       = (count_q == (PTR_W + 1)'(DEPTH));
  assign cmd_ready  = rst & ~full;
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign port_ready = write_q ? wr_ready : rd_ready;
  assign tmo_hit    = (TIMEOUT != 0) && ((32'(tmo_q) + 32'd1) == 32'(TIMEOUT));

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata};
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {write_d, addr_d, data_d} = head;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (port_ready) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_err_d   = 1'b0;
          rsp_data_d  = write_q ? '0 : rd_data;
          state_d     = ST_RESP;
        end else if (tmo_hit) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // req is already low here, giving the cache its mandatory idle cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          addr_d      = '0;
          data_d      = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_q       <= req_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      tmo_q       <= tmo_d;
    end
  end

  // Address/data buses read as zero whenever their port has no request up.
  assign rd_req     = req_q & ~write_q;
  assign wr_req     = req_q & write_q;
  assign rd_addr    = rd_req ? addr_q : '0;
  assign wr_addr    = wr_req ? addr_q : '0;
  assign wr_data    = wr_req ? data_q : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != ST_IDLE) | (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_cache_client_port.sv
// Randomized bench for cache_client_port: the bench plays the cache and the
// command/response sides and checks against an in-order memory model.
module tb_cache_client_port;

  typedef struct {logic w; logic [13:0] a; logic [9:0] d;} cmd_t;
  typedef struct {logic w; logic [9:0] d;} exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [13:0] cmd_addr = '0;
  logic [9:0]  cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [9:0]  rsp_data;
  logic        rd_req, wr_req, busy;
  logic [13:0] rd_addr, wr_addr;
  logic [9:0]  wr_data;
  logic [9:0]  rd_data = '0;
  logic        rd_ready = 1'b0, wr_ready = 1'b0;
  logic [2:0]  fifo_count;

  logic        t_cmd_valid = 1'b0, t_cmd_ready, t_rsp_valid, t_rsp_write, t_rsp_err;
  logic        t_rsp_ready = 1'b0;
  logic [9:0]  t_rsp_data, t_wr_data;
  logic        t_rd_req, t_wr_req, t_busy;
  logic [13:0] t_rd_addr, t_wr_addr;
  logic [2:0]  t_fifo_count;

  always #5 clk = ~clk;

  cache_client_port #(.ADDR_W(14), .DATA_W(10), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ready(rd_ready), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .fifo_count(fifo_count)
  );

  // Second instance with a short timeout and a cache that never answers reads.
  cache_client_port #(.ADDR_W(14), .DATA_W(10), .DEPTH(4), .TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_write(1'b0), .cmd_addr(14'd7), .cmd_wdata(10'd0),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_write(t_rsp_write),
    .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .rd_req(t_rd_req), .rd_addr(t_rd_addr),
    .rd_data(10'h3ff), .rd_ready(1'b0), .wr_req(t_wr_req), .wr_addr(t_wr_addr),
    .wr_data(t_wr_data), .wr_ready(1'b1), .busy(t_busy), .fifo_count(t_fifo_count)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] dflt(input logic [13:0] a);
    logic [13:0] m;
    m = a * 14'd7;
    return m[9:0] ^ 10'h155;
  endfunction

  cmd_t        cmd_q[$];
  exp_t        exp_q[$];
  logic [9:0]  model_mem [logic [13:0]];
  logic [9:0]  cache_mem [logic [13:0]];
  bit          mon_en = 0;
  int          cmd_mode = 1, rsp_mode = 1, force_delay = 0;
  int          pushed = 0, issued = 0, stall_cnt = 0, rsp_seen = 0;
  int          k = 0, d = 0;
  logic        lat_w = 1'b0;
  logic [13:0] lat_a = '0;
  logic [9:0]  lat_d = '0;
  bit          prev_pending = 0;
  logic [11:0] prev_rsp = '0;

  task automatic model_push(input cmd_t c);
    exp_t e;
    e.w = c.w;
    if (c.w) begin
      model_mem[c.a] = c.d;
      e.d = '0;
    end else begin
      e.d = model_mem.exists(c.a) ? model_mem[c.a] : dflt(c.a);
    end
    exp_q.push_back(e);
  endtask

  task automatic mon_step();
    logic req_now, acc;
    int   exp_cnt;
    cmd_t c;
    exp_t e;
    req_now = rd_req | wr_req;
    acc = 1'b0;
    chk("req_excl", 32'(rd_req & wr_req), 32'd0);
    if (!rd_req) chk("rd_addr_idle", 32'(rd_addr), 32'd0);
    if (!wr_req) chk("wr_bus_idle", 32'({wr_addr, wr_data}), 32'd0);
    // cache side
    if (req_now) begin
      if (k == 0) begin
        issued++;
        d = (force_delay != 0) ? force_delay : int'($urandom_range(1, 8));
        lat_w = wr_req;
        lat_a = wr_req ? wr_addr : rd_addr;
        lat_d = wr_data;
      end else begin
        chk("req_type", 32'(wr_req), 32'(lat_w));
        chk("req_addr", 32'(lat_w ? wr_addr : rd_addr), 32'(lat_a));
        if (lat_w) chk("req_wdata", 32'(wr_data), 32'(lat_d));
      end
      k++;
      acc = (k >= d);
    end else begin
      if (k != 0) begin
        chk("req_len", 32'(k), 32'(d));
        chk("rsp_after_ready", 32'(rsp_valid), 32'd1);
      end
      k = 0;
    end
    rd_ready = 1'($urandom_range(0, 1));
    wr_ready = 1'($urandom_range(0, 1));
    rd_data  = 10'($urandom);
    if (req_now) begin
      if (lat_w) begin
        wr_ready = acc;
        if (acc) cache_mem[lat_a] = lat_d;
      end else begin
        rd_ready = acc;
        if (acc) rd_data = cache_mem.exists(lat_a) ? cache_mem[lat_a] : dflt(lat_a);
      end
    end
    // FIFO occupancy and status
    exp_cnt = pushed - issued;
    chk("fifo_count", 32'(fifo_count), 32'(exp_cnt));
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_cnt < 4));
    chk("busy", 32'(busy), 32'(exp_cnt != 0 || req_now || rsp_valid));
    if (rsp_valid) chk("no_req_in_resp", 32'(req_now), 32'd0);
    // response side
    if (prev_pending)
      chk("rsp_hold", 32'({rsp_valid, rsp_write, rsp_err, rsp_data}), 32'({1'b1, prev_rsp}));
    case (rsp_mode)
      1:       rsp_ready = 1'b1;
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (exp_q.size() == 0) chk("rsp_extra", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp", 32'({rsp_write, rsp_err, rsp_data}), 32'({e.w, 1'b0, e.d}));
      end
    end
    prev_pending = rsp_valid && !rsp_ready;
    prev_rsp = {rsp_write, rsp_err, rsp_data};
    // command side
    if (cmd_q.size() != 0 && (cmd_mode == 1 || $urandom_range(0, 3) != 0)) begin
      c = cmd_q[0];
      cmd_valid = 1'b1; cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d;
      if (cmd_ready) begin
        void'(cmd_q.pop_front());
        model_push(c);
        pushed++;
      end else stall_cnt++;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 14'($urandom);
      cmd_wdata = 10'($urandom);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) mon_step();
  end

  task automatic push_cmd(input logic w, input logic [13:0] a, input logic [9:0] dt);
    cmd_t c;
    c.w = w; c.a = a; c.d = dt;
    cmd_q.push_back(c);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cmd_q.size() == 0 && exp_q.size() == 0 && !busy) return;
    end
    chk("drain_timeout", 32'(exp_q.size() + cmd_q.size()), 32'd0);
  endtask

  initial begin
    int n, base;
    bit seen, got;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req", 32'({rd_req, wr_req}), 32'd0);
    chk("rst_buses", 32'({rd_addr, wr_addr, wr_data}), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // timeout instance: read never answered, inactive write-ready held high
    @(negedge clk);
    t_cmd_valid = 1'b1;
    chk("t_cmd_ready", 32'(t_cmd_ready), 32'd1);
    @(negedge clk) t_cmd_valid = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (t_rd_req) begin n++; seen = 1; end
      else if (seen) break;
    end
    chk("tmo_len", 32'(n), 32'd8);
    chk("tmo_rsp", 32'({t_rsp_valid, t_rsp_err, t_rsp_write, t_rsp_data}), 32'({1'b1, 1'b1, 1'b0, 10'd0}));
    t_rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo_rsp_done", 32'(t_rsp_valid), 32'd0);
    t_rsp_ready = 1'b0;
    @(negedge clk);
    chk("tmo_idle", 32'({t_busy, t_wr_req}), 32'd0);

    mon_en = 1;
    // single read, cache ready after 3 cycles
    cmd_mode = 1; rsp_mode = 1; force_delay = 3;
    push_cmd(1'b0, 14'd0, 10'd0);
    wait_drain(100);
    // single write, cache ready after 12 cycles
    force_delay = 12;
    push_cmd(1'b1, 14'd4, 10'd228);
    wait_drain(100);

    // hold a response, fill the FIFO behind it, then drain in order
    force_delay = 2; rsp_mode = 2;
    push_cmd(1'b0, 14'd1, 10'd0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(posedge clk); #1; got = rsp_valid; end
    chk("held_rsp_seen", 32'(got), 32'd1);
    base = rsp_seen; stall_cnt = 0;
    push_cmd(1'b0, 14'd3, 10'd0);
    push_cmd(1'b1, 14'd4, 10'h2aa);
    push_cmd(1'b0, 14'd5, 10'd0);
    push_cmd(1'b1, 14'd64, 10'h011);
    push_cmd(1'b0, 14'd96, 10'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("fifo_full", 32'(fifo_count), 32'd4);
    chk("fifth_pending", 32'(cmd_q.size()), 32'd1);
    chk("stalled", 32'(stall_cnt > 0), 32'd1);
    rsp_mode = 1;
    wait_drain(200);
    chk("burst_rsp_count", 32'(rsp_seen - base), 32'd6);

    // randomized traffic
    force_delay = 0; rsp_mode = 0; cmd_mode = 0;
    for (int i = 0; i < 60; i++)
      push_cmd(1'($urandom), 14'($urandom_range(0, 15)), 10'($urandom));
    wait_drain(3000);

    // reset in the middle of a request
    rsp_mode = 1; cmd_mode = 1; force_delay = 10;
    push_cmd(1'b0, 14'd20, 10'd0);
    push_cmd(1'b0, 14'd21, 10'd0);
    push_cmd(1'b0, 14'd22, 10'd0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(posedge clk); #1; got = rd_req; end
    chk("pre_rst_req", 32'(got), 32'd1);
    repeat (2) @(posedge clk);
    mon_en = 0;
    #2 rst = 1'b0;
    cmd_valid = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
    #1;
    chk("mid_rst_req", 32'({rd_req, wr_req}), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_q.delete(); exp_q.delete();
    pushed = 0; issued = 0; k = 0; prev_pending = 0;
    @(negedge clk) rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'({cmd_ready, busy}), 32'({1'b1, 1'b0}));
    mon_en = 1;
    force_delay = 1;
    push_cmd(1'b0, 14'd4, 10'd0);
    wait_drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
